mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage sequencer that sits directly downstream of memoryHelper.
- Accepts one load/store op from the execute/memory pipeline register and drives memoryHelper's addr/msize/strobe/data onto the data bus with a valid/addr_ok/data_ok handshake.
- Stalls the pipeline until the bus completes, then aligns and sign/zero-extends load data.
- Delivers the result, or a misaligned/timeout exception, to writeback.

Parameters:
- WAIT_LIMIT, 0, maximum cycles from request issue to data_ok before raising bus_err; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream op present
- in_ready  output  1  unit can accept an op this cycle
- in_addr  input  u64  effective address
- in_wdata  input  u64  store source register value
- in_mode  input  u4  memMode encoding
- dreq  output  dbus_req_t  {valid, addr, size, strobe, data}
- dresp  input  dbus_resp_t  {addr_ok, data_ok, data}
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_data  output  u64  extended load value; 0 for stores
- out_misaligned  output  1  misaligned-access exception
- out_bus_err  output  1  timeout exception

Behaviour:
- Mode encoding:
  - Loads: 0000 lb, 0001 lh, 0010 lw, 0011 ld, 0100 lbu, 0101 lhu, 0110 lwu.
  - Stores: 1000 sb, 1001 sh, 1010 sw, 1011 sd.
  - Any other value is NONE (no memory access).
- Input capture: addr, wdata and mode are registered on the in_valid && in_ready handshake. memoryHelper is driven from these registered values only.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On accept with mode NONE or misaligned: go to DONE. No bus activity.
  - On any other accept: go to REQ.
- REQ:
  - dreq.valid=1. addr/size/strobe/data come from memoryHelper and stay stable until addr_ok.
  - addr_ok && data_ok in the same cycle: go to DONE and latch dresp.data.
  - addr_ok only: go to WAIT.
- WAIT:
  - dreq.valid=0.
  - On data_ok: latch dresp.data and go to DONE.
- DONE:
  - out_valid=1. Outputs stay stable until out_ready.
  - out_valid && out_ready: return to IDLE.
  - No back-to-back accept in that same cycle; in_ready is 0 in REQ, WAIT and DONE.
- Load extraction:
  - Shift the latched bus data right by 8*addr[2:0].
  - Take width by mode[1:0]: 8, 16, 32 or 64 bits.
  - Sign-extend when mode[2]=0; zero-extend when mode[2]=1.
  - ld ignores mode[2].
- Store result: out_data=0. NONE result: out_data=0.
- Misaligned access: out_misaligned=1 in DONE. dreq.valid never asserts for that op.
- Timeout (when WAIT_LIMIT>0):
  - Counter clears on entering REQ and increments every cycle in REQ and WAIT.
  - When the count reaches WAIT_LIMIT without data_ok: go to DONE with out_bus_err=1 and out_data=0.
  - A data_ok in the same cycle as the limit wins: no error.
- data_ok arriving in DONE or IDLE is ignored.
- Latency: minimum 2 cycles from accept to out_valid for a bus access (REQ, then DONE); 1 cycle for NONE or misaligned.
- Reset, applied in any state, takes effect at the next clk edge:
  - State goes to IDLE; counter and latches clear.
  - out_valid, out_misaligned, out_bus_err, dreq.valid and out_data are 0.
  - in_ready is 1 after reset.
  - Any in-flight bus transaction is abandoned.

Decomposition:
- Shared package (common) holds:
  - MEM_LB..MEM_SD and MEM_NONE mode constants.
  - The mau_state_t enum {IDLE, REQ, WAIT, DONE}.
  - The existing dbus_req_t/dbus_resp_t types.
- Instantiate memoryHelper for request formatting.
- One natural sub-module: load_extract (combinational: addr[2:0], mode, raw word -> extended u64).

Test Plan:
- lb at addr 0x1003, bus data 0x0000_0000_8000_0000, addr_ok+data_ok in REQ -> out_data=0xFFFF_FFFF_FFFF_FF80 one cycle after REQ; lbu -> 0x80.
- sh at addr 0x2006, wdata 0xBEEF, addr_ok delayed 3 cycles then data_ok 2 cycles later -> request fields hold stable for 3 cycles (strobe 0xC0, data 0xBEEF<<48); out_valid after data_ok; out_data=0.
- lw at addr 0x3002 -> out_misaligned=1, dreq.valid never high, out_valid on the cycle after accept.
- WAIT_LIMIT=4, addr_ok given, data_ok never arrives -> out_bus_err=1 after 4 cycles; out_ready held low 5 cycles -> outputs stable throughout.
- Reset asserted while in WAIT -> next cycle state IDLE, dreq.valid=0, out_valid=0, in_ready=1; a late data_ok is ignored.
- ld at addr 0x4000 returning 0x0123_4567_89AB_CDEF, followed immediately by in_valid for mode NONE -> ld result first, then NONE result with out_data=0; no overlap.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
//------------------------------------------------------------------------------
// Module      : mem_access_unit_pkg
// Description : Shared mode constants, FSM state type and data-bus types.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_access_unit_pkg;

    localparam logic [3:0] MEM_LB   = 4'b0000;
    localparam logic [3:0] MEM_LH   = 4'b0001;
    localparam logic [3:0] MEM_LW   = 4'b0010;
    localparam logic [3:0] MEM_LD   = 4'b0011;
    localparam logic [3:0] MEM_LBU  = 4'b0100;
    localparam logic [3:0] MEM_LHU  = 4'b0101;
    localparam logic [3:0] MEM_LWU  = 4'b0110;
    localparam logic [3:0] MEM_NONE = 4'b0111;
    localparam logic [3:0] MEM_SB   = 4'b1000;
    localparam logic [3:0] MEM_SH   = 4'b1001;
    localparam logic [3:0] MEM_SW   = 4'b1010;
    localparam logic [3:0] MEM_SD   = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mau_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    function automatic logic mode_is_load(input logic [3:0] mode);
        return (mode[3] == 1'b0) && (mode[2:0] != 3'b111);
    endfunction

    function automatic logic mode_is_store(input logic [3:0] mode);
        return (mode[3:2] == 2'b10);
    endfunction

    // Natural alignment check; non-memory modes are never misaligned.
    function automatic logic addr_misaligned(input logic [2:0] offset, input logic [3:0] mode);
        logic r;
        case (mode[1:0])
            2'd1:    r = offset[0];
            2'd2:    r = |offset[1:0];
            2'd3:    r = |offset;
            default: r = 1'b0;
        endcase
        return r && (mode_is_load(mode) || mode_is_store(mode));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_extract.sv
//------------------------------------------------------------------------------
// Module      : load_extract
// Description : Aligns raw bus data by byte offset and sign/zero-extends it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_extract (
    input  logic [2:0]  offset,
    input  logic [2:0]  mode,
    input  logic [63:0] raw,
    output logic [63:0] ext
);

    logic [63:0] w_shifted;
    logic        w_zero;

    assign w_shifted = raw >> {offset, 3'b000};
    assign w_zero    = mode[2];

    always_comb begin
        ext = w_shifted;
        case (mode[1:0])
            2'd0: ext = w_zero ? {56'd0, w_shifted[7:0]}  : {{56{w_shifted[7]}},  w_shifted[7:0]};
            2'd1: ext = w_zero ? {48'd0, w_shifted[15:0]} : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'd2: ext = w_zero ? {32'd0, w_shifted[31:0]} : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: ext = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit_memory_helper.sv
//------------------------------------------------------------------------------
// Module      : memoryHelper
// Description : Formats address/size/strobe/data for the data bus from a mode.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module memoryHelper
    import mem_access_unit_pkg::*;
(
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [3:0]  mode,
    output logic [63:0] req_addr,
    output logic [2:0]  req_size,
    output logic [7:0]  req_strobe,
    output logic [63:0] req_data,
    output logic        misaligned
);

    logic [7:0]  w_mask;
    logic [63:0] w_wmask;
    logic [5:0]  w_shift;

    always_comb begin
        w_mask  = 8'h00;
        w_wmask = 64'd0;
        case (mode[1:0])
            2'd0: begin w_mask = 8'h01; w_wmask = 64'h0000_0000_0000_00FF; end
            2'd1: begin w_mask = 8'h03; w_wmask = 64'h0000_0000_0000_FFFF; end
            2'd2: begin w_mask = 8'h0F; w_wmask = 64'h0000_0000_FFFF_FFFF; end
            default: begin w_mask = 8'hFF; w_wmask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
    end

    assign w_shift    = {addr[2:0], 3'b000};
    assign req_addr   = addr;
    assign req_size   = {1'b0, mode[1:0]};
    assign req_strobe = mode_is_store(mode) ? (w_mask << addr[2:0]) : 8'h00;
    assign req_data   = (wdata & w_wmask) << w_shift;
    assign misaligned = addr_misaligned(addr[2:0], mode);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// Module      : mem_access_unit
// Description : Memory-stage sequencer: issues one bus access, stalls until it
//               completes and returns the extended result or an exception.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [3:0]  in_mode,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_misaligned,
    output logic        out_bus_err
);

    localparam int unsigned         c_CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(WAIT_LIMIT);

    mau_state_t         r_state;
    mau_state_t         w_next_state;
    logic [63:0]        r_addr;
    logic [63:0]        r_wdata;
    logic [3:0]         r_mode;
    logic [63:0]        r_rdata;
    logic               r_bus_err;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;

    logic               w_accept;
    logic               w_skip_bus;
    logic               w_timeout;
    logic [63:0]        w_req_addr;
    logic [2:0]         w_req_size;
    logic [7:0]         w_req_strobe;
    logic [63:0]        w_req_data;
    logic               w_misaligned;
    logic [63:0]        w_ext;

    memoryHelper u_helper (
        .addr       (r_addr),
        .wdata      (r_wdata),
        .mode       (r_mode),
        .req_addr   (w_req_addr),
        .req_size   (w_req_size),
        .req_strobe (w_req_strobe),
        .req_data   (w_req_data),
        .misaligned (w_misaligned)
    );

    load_extract u_extract (
        .offset (r_addr[2:0]),
        .mode   (r_mode[2:0]),
        .raw    (r_rdata),
        .ext    (w_ext)
    );

    assign w_accept   = in_valid && (r_state == IDLE);
    // The skip decision is made at accept time, so it looks at the incoming op.
    assign w_skip_bus = !(mode_is_load(in_mode) || mode_is_store(in_mode))
                        || addr_misaligned(in_addr[2:0], in_mode);
    assign w_cnt_inc  = r_cnt + c_CNT_W'(1);
    assign w_timeout  = (WAIT_LIMIT != 0) && (w_cnt_inc == c_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = w_skip_bus ? DONE : REQ;
            REQ: begin
                if (dresp.addr_ok && dresp.data_ok) w_next_state = DONE;
                else if (w_timeout)                 w_next_state = DONE;
                else if (dresp.addr_ok)             w_next_state = WAIT;
            end
            WAIT: if (dresp.data_ok || w_timeout) w_next_state = DONE;
            DONE: if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= 64'd0;
            r_wdata   <= 64'd0;
            r_mode    <= MEM_NONE;
            r_rdata   <= 64'd0;
            r_bus_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_addr    <= in_addr;
                r_wdata   <= in_wdata;
                r_mode    <= in_mode;
                r_rdata   <= 64'd0;
                r_bus_err <= 1'b0;
                r_cnt     <= '0;
            end
            if (r_state == REQ) begin
                r_cnt <= w_cnt_inc;
                if (dresp.addr_ok && dresp.data_ok) r_rdata   <= dresp.data;
                else if (w_timeout)                 r_bus_err <= 1'b1;
            end
            if (r_state == WAIT) begin
                r_cnt <= w_cnt_inc;
                if (dresp.data_ok)  r_rdata   <= dresp.data;
                else if (w_timeout) r_bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        in_ready       = (r_state == IDLE);
        dreq.valid     = (r_state == REQ);
        dreq.addr      = w_req_addr;
        dreq.size      = w_req_size;
        dreq.strobe    = w_req_strobe;
        dreq.data      = w_req_data;
        out_valid      = (r_state == DONE);
        out_misaligned = (r_state == DONE) && w_misaligned;
        out_bus_err    = (r_state == DONE) && r_bus_err;
        out_data       = 64'd0;
        if ((r_state == DONE) && mode_is_load(r_mode) && !w_misaligned && !r_bus_err) begin
            out_data = w_ext;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [3:0]  in_mode;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_mis_a, out_err_a;
    logic [63:0] out_data_a;
    dbus_req_t   dreq_a;
    dbus_resp_t  dresp_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_mis_b, out_err_b;
    logic [63:0] out_data_b;
    dbus_req_t   dreq_b;
    dbus_resp_t  dresp_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_unit dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_mode(in_mode),
        .dreq(dreq_a), .dresp(dresp_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .out_misaligned(out_mis_a), .out_bus_err(out_err_a)
    );

    mem_access_unit #(.WAIT_LIMIT(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_mode(in_mode),
        .dreq(dreq_b), .dresp(dresp_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_misaligned(out_mis_b), .out_bus_err(out_err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept_a(input logic [3:0] mode, input logic [63:0] addr, input logic [63:0] wdata);
        in_mode    = mode;
        in_addr    = addr;
        in_wdata   = wdata;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
    endtask

    task automatic retire_a();
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_addr = 64'd0; in_wdata = 64'd0; in_mode = MEM_NONE;
        in_valid_a = 1'b0; out_ready_a = 1'b0; dresp_a = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; dresp_b = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_in_ready",  in_ready_a,  1'b1);
        check("rst_out_valid", out_valid_a, 1'b0);
        check("rst_dreq_valid", dreq_a.valid, 1'b0);
        check("rst_out_data",  out_data_a,  64'd0);
        check("rst_b_in_ready", in_ready_b, 1'b1);

        // lb at 0x1003: byte 3 of the bus word is 0x80, sign-extended
        accept_a(MEM_LB, 64'h1003, 64'd0);
        check("lb_req_valid",  dreq_a.valid,  1'b1);
        check("lb_in_ready",   in_ready_a,    1'b0);
        check("lb_req_addr",   dreq_a.addr,   64'h1003);
        check("lb_req_size",   dreq_a.size,   3'd0);
        dresp_a = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0000_0000_8000_0000};
        tick();
        dresp_a = '0;
        check("lb_out_valid",  out_valid_a,   1'b1);
        check("lb_out_data",   out_data_a,    64'hFFFF_FFFF_FFFF_FF80);
        check("lb_dreq_idle",  dreq_a.valid,  1'b0);
        retire_a();
        check("lb_retired",    out_valid_a,   1'b0);

        accept_a(MEM_LBU, 64'h1003, 64'd0);
        dresp_a = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0000_0000_8000_0000};
        tick();
        dresp_a = '0;
        check("lbu_out_data",  out_data_a,    64'h80);
        retire_a();

        // sh at 0x2006: bytes 6..7, request held while addr_ok is withheld
        accept_a(MEM_SH, 64'h2006, 64'h0000_0000_0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            check("sh_req_valid",  dreq_a.valid,  1'b1);
            check("sh_req_strobe", dreq_a.strobe, 8'hC0);
            check("sh_req_data",   dreq_a.data,   64'hBEEF_0000_0000_0000);
            check("sh_req_size",   dreq_a.size,   3'd1);
            if (i < 2) tick();
        end
        dresp_a.addr_ok = 1'b1;
        tick();
        dresp_a = '0;
        check("sh_wait_valid", dreq_a.valid,  1'b0);
        check("sh_wait_out",   out_valid_a,   1'b0);
        tick();
        check("sh_wait_out2",  out_valid_a,   1'b0);
        dresp_a.data_ok = 1'b1;
        tick();
        dresp_a = '0;
        check("sh_out_valid",  out_valid_a,   1'b1);
        check("sh_out_data",   out_data_a,    64'd0);
        check("sh_misaligned", out_mis_a,     1'b0);
        retire_a();

        // lw at 0x3002 is misaligned: straight to DONE, no request
        accept_a(MEM_LW, 64'h3002, 64'd0);
        check("mis_out_valid", out_valid_a,   1'b1);
        check("mis_flag",      out_mis_a,     1'b1);
        check("mis_dreq",      dreq_a.valid,  1'b0);
        check("mis_out_data",  out_data_a,    64'd0);
        retire_a();

        // reset while in WAIT, then a stale data_ok
        accept_a(MEM_LW, 64'h5000, 64'd0);
        dresp_a.addr_ok = 1'b1;
        tick();
        dresp_a = '0;
        check("rw_in_wait",    dreq_a.valid,  1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_in_ready",   in_ready_a,    1'b1);
        check("rw_out_valid",  out_valid_a,   1'b0);
        check("rw_dreq_valid", dreq_a.valid,  1'b0);
        dresp_a = '{addr_ok: 1'b0, data_ok: 1'b1, data: 64'hDEAD_BEEF_DEAD_BEEF};
        tick();
        dresp_a = '0;
        check("rw_late_ok",    out_valid_a,   1'b0);
        check("rw_late_ready", in_ready_a,    1'b1);

        // ld followed by a NONE op waiting upstream
        accept_a(MEM_LD, 64'h4000, 64'd0);
        dresp_a = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0123_4567_89AB_CDEF};
        in_mode = MEM_NONE;
        in_addr = 64'h7777;
        in_valid_a = 1'b1;
        tick();
        dresp_a = '0;
        check("ld_out_data",   out_data_a,    64'h0123_4567_89AB_CDEF);
        check("ld_in_ready",   in_ready_a,    1'b0);
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        check("ld_no_overlap", out_valid_a,   1'b0);
        check("none_ready",    in_ready_a,    1'b1);
        tick();
        in_valid_a = 1'b0;
        check("none_out_valid", out_valid_a,  1'b1);
        check("none_out_data", out_data_a,    64'd0);
        check("none_mis",      out_mis_a,     1'b0);
        check("none_dreq",     dreq_a.valid,  1'b0);
        retire_a();

        // timeout: WAIT_LIMIT=4, data_ok never comes
        in_mode = MEM_LW; in_addr = 64'h6000; in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        check("to_req_valid",  dreq_b.valid,  1'b1);
        dresp_b.addr_ok = 1'b1;
        tick();
        dresp_b = '0;
        check("to_wait_valid", dreq_b.valid,  1'b0);
        tick();
        check("to_pending1",   out_valid_b,   1'b0);
        tick();
        check("to_pending2",   out_valid_b,   1'b0);
        tick();
        check("to_out_valid",  out_valid_b,   1'b1);
        check("to_bus_err",    out_err_b,     1'b1);
        check("to_out_data",   out_data_b,    64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("to_hold_valid", out_valid_b, 1'b1);
            check("to_hold_err",   out_err_b,   1'b1);
            check("to_hold_data",  out_data_b,  64'd0);
        end
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
        check("to_retired",    out_valid_b,   1'b0);
        check("to_in_ready",   in_ready_b,    1'b1);
        check("to_mis",        out_mis_b,     1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
